// File: rtl/content_loss_pkg.sv
// Shared types and width helpers for the content-loss streaming datapath.
// Widths are derived here so the sub-module and top always agree.
package content_loss_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    function automatic int sum_width(input int pix_w, input int lanes);
        return 2 * (pix_w + 1) + $clog2(lanes);
    endfunction

    function automatic int acc_width(input int pix_w, input int lanes,
                                     input int beats);
        return sum_width(pix_w, lanes) + $clog2(beats) + 1;
    endfunction

endpackage

// File: rtl/content_loss_stream_sq_diff_sum.sv
// Stages 1-2: per-lane signed difference and square, then exact lane sum.
// Valid and last-beat markers travel alongside the data.
module sq_diff_sum
    import content_loss_pkg::*;
#(
    parameter int PIX_W = 16,
    parameter int LANES = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                beat_valid,
    input  logic                                beat_last,
    input  logic [LANES*PIX_W-1:0]              content_pixels,
    input  logic [LANES*PIX_W-1:0]              generated_pixels,
    output logic                                sum_valid,
    output logic                                sum_last,
    output logic [sum_width(PIX_W, LANES)-1:0]  lane_sum
);

    localparam int SQ_W  = 2 * (PIX_W + 1);
    localparam int SUM_W = sum_width(PIX_W, LANES);

    logic signed [PIX_W:0]  diff   [LANES];
    logic signed [SQ_W-1:0] diff_x [LANES];
    logic [SQ_W-1:0]        sq_d   [LANES];
    logic [SQ_W-1:0]        sq_q   [LANES];
    logic [SUM_W-1:0]       sum_d;
    logic                   s1_valid;
    logic                   s1_last;

    // Zero-extend both operands so the subtraction is a true signed difference
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            diff[i]   = $signed({1'b0, content_pixels[i*PIX_W +: PIX_W]})
                      - $signed({1'b0, generated_pixels[i*PIX_W +: PIX_W]});
            diff_x[i] = {{(PIX_W+1){diff[i][PIX_W]}}, diff[i]};
            sq_d[i]   = diff_x[i] * diff_x[i];
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_d = sum_d + SUM_W'(sq_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            sum_valid <= 1'b0;
            sum_last  <= 1'b0;
        end else begin
            s1_valid  <= beat_valid;
            s1_last   <= beat_valid & beat_last;
            sum_valid <= s1_valid;
            sum_last  <= s1_last;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_valid) begin
            for (int i = 0; i < LANES; i++) begin
                sq_q[i] <= sq_d[i];
            end
        end
        if (s1_valid) begin
            lane_sum <= sum_d;
        end
    end

endmodule

// File: rtl/content_loss_stream.sv
// Streaming half-sum-of-squared-differences loss over BEATS beats per frame.
// Stage 3 accumulates lane sums; the FSM gates input and result handshakes.
module content_loss_stream
    import content_loss_pkg::*;
#(
    parameter int PIX_W = 16,
    parameter int LANES = 64,
    parameter int BEATS = 4,
    parameter int OUT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*PIX_W-1:0] content_pixels,
    input  logic [LANES*PIX_W-1:0] generated_pixels,
    output logic                   loss_valid,
    input  logic                   loss_ready,
    output logic [OUT_W-1:0]       loss_out,
    output logic                   loss_sat
);

    localparam int SUM_W  = sum_width(PIX_W, LANES);
    localparam int ACC_W  = acc_width(PIX_W, LANES, BEATS);
    localparam int LOSS_W = ACC_W - 1;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic [LOSS_W-1:0]  loss;
    logic [OUT_W-1:0]   out_raw;
    logic               sat_raw;
    logic               accept;
    logic               last_beat;
    logic               res_hs;
    logic               sum_valid;
    logic               sum_last;
    logic [SUM_W-1:0]   lane_sum;

    assign in_ready   = !rst && (state == IDLE || state == ACCUM);
    assign loss_valid = !rst && (state == DONE);
    assign accept     = in_valid && in_ready;
    assign last_beat  = (cnt == CNT_W'(BEATS - 1));
    assign res_hs     = loss_valid && loss_ready;

    sq_diff_sum #(
        .PIX_W (PIX_W),
        .LANES (LANES)
    ) u_sq (
        .clk              (clk),
        .rst              (rst),
        .beat_valid       (accept),
        .beat_last        (last_beat),
        .content_pixels   (content_pixels),
        .generated_pixels (generated_pixels),
        .sum_valid        (sum_valid),
        .sum_last         (sum_last),
        .lane_sum         (lane_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                cnt <= last_beat ? '0 : cnt + CNT_W'(1);
            end
            if (res_hs) begin
                acc <= '0;
            end else if (sum_valid) begin
                acc <= acc + ACC_W'(lane_sum);
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) state_n = last_beat ? DRAIN : ACCUM;
            end
            ACCUM: begin
                if (accept && last_beat) state_n = DRAIN;
            end
            DRAIN: begin
                if (sum_valid && sum_last) state_n = DONE;
            end
            DONE: begin
                if (res_hs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign loss = LOSS_W'(acc >> 1);

    generate
        if (LOSS_W > OUT_W) begin : g_sat
            assign sat_raw = |loss[LOSS_W-1:OUT_W];
            assign out_raw = sat_raw ? '1 : loss[OUT_W-1:0];
        end else begin : g_nosat
            assign sat_raw = 1'b0;
            assign out_raw = OUT_W'(loss);
        end
    endgenerate

    // Result only leaves the block in DONE; otherwise the outputs read as zero
    assign loss_out = loss_valid ? out_raw : '0;
    assign loss_sat = loss_valid && sat_raw;

endmodule

// File: tb/tb_content_loss_stream.sv
// Directed bench for content_loss_stream with a frame-level reference model.
// A second instance with BEATS=1 covers the single-beat frame path.
module tb_content_loss_stream;

    localparam int PW = 16;
    localparam int LN = 64;
    localparam int NB = 4;
    localparam int W  = PW * LN;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  content_pixels;
    logic [W-1:0]  generated_pixels;
    logic          loss_valid;
    logic          loss_ready;
    logic [31:0]   loss_out;
    logic          loss_sat;

    logic          in_valid1;
    logic          in_ready1;
    logic          loss_valid1;
    logic          loss_ready1;
    logic [31:0]   loss_out1;
    logic          loss_sat1;

    int total = 0;
    int bad   = 0;

    bit      closed = 0;
    bit      ev = 0;
    int      cd = 0;
    longint  fsum = 0;
    int      fbeats = 0;
    logic [31:0] e_out = '0;
    bit      e_sat = 0;
    int      results_seen = 0;
    int      frames_sent = 0;

    always #5 clk = ~clk;

    content_loss_stream #(
        .PIX_W(PW), .LANES(LN), .BEATS(NB), .OUT_W(32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .content_pixels   (content_pixels),
        .generated_pixels (generated_pixels),
        .loss_valid       (loss_valid),
        .loss_ready       (loss_ready),
        .loss_out         (loss_out),
        .loss_sat         (loss_sat)
    );

    content_loss_stream #(
        .PIX_W(PW), .LANES(LN), .BEATS(1), .OUT_W(32)
    ) dut1 (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid1),
        .in_ready         (in_ready1),
        .content_pixels   (content_pixels),
        .generated_pixels (generated_pixels),
        .loss_valid       (loss_valid1),
        .loss_ready       (loss_ready1),
        .loss_out         (loss_out1),
        .loss_sat         (loss_sat1)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] fill(input logic [15:0] v);
        return {LN{v}};
    endfunction

    function automatic longint beat_sum(input logic [W-1:0] c,
                                        input logic [W-1:0] g);
        longint s = 0;
        longint d;
        for (int i = 0; i < LN; i++) begin
            d = longint'(c[i*PW +: PW]) - longint'(g[i*PW +: PW]);
            s += d * d;
        end
        return s;
    endfunction

    // Reference model: frame-level sums, result due 3 cycles after last beat
    always @(negedge clk) begin
        longint lv;
        if (rst) begin
            closed = 0; ev = 0; cd = 0; fsum = 0; fbeats = 0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) ev = 1;
        end
        chk("in_ready", in_ready, !rst && !closed);
        chk("loss_valid", loss_valid, ev);
        if (ev) begin
            chk("loss_out", loss_out, e_out);
            chk("loss_sat", loss_sat, e_sat);
        end else if (rst) begin
            chk("rst_loss_out", loss_out, 0);
            chk("rst_loss_sat", loss_sat, 0);
        end
        if (!rst) begin
            if (ev && loss_ready) begin
                ev = 0; closed = 0; results_seen++;
            end else if (in_valid && !closed) begin
                fsum += beat_sum(content_pixels, generated_pixels);
                fbeats++;
                if (fbeats == NB) begin
                    lv    = fsum >>> 1;
                    e_sat = (lv > 64'hFFFF_FFFF);
                    e_out = e_sat ? 32'hFFFF_FFFF : lv[31:0];
                    cd = 3; closed = 1; fsum = 0; fbeats = 0;
                end
            end
        end
    end

    task automatic send_beat(input logic [W-1:0] c, input logic [W-1:0] g);
        bit hs = 0;
        int n = 0;
        content_pixels   = c;
        generated_pixels = g;
        in_valid = 1'b1;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!hs) chk("send_timeout", 0, 1);
    endtask

    task automatic send_frame(input logic [W-1:0] c, input logic [W-1:0] g);
        for (int b = 0; b < NB; b++) send_beat(c, g);
        frames_sent++;
    endtask

    task automatic wait_result(output int lat, output logic [31:0] o,
                               output logic s);
        lat = 0;
        o = '0;
        s = 1'b0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (loss_valid) break;
        end
        if (!loss_valid) chk("result_timeout", 0, 1);
        o = loss_out;
        s = loss_sat;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        logic [31:0] o;
        logic s;
        logic [W-1:0] rc;
        logic [W-1:0] rg;
        bit hs;
        int n;

        rst = 1'b1;
        in_valid = 1'b0;
        in_valid1 = 1'b0;
        loss_ready = 1'b1;
        loss_ready1 = 1'b1;
        content_pixels = '0;
        generated_pixels = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_loss_valid", loss_valid, 0);
        chk("reset_loss_out", loss_out, 0);
        chk("reset_in_ready1", in_ready1, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Equal inputs give zero loss, result three cycles after last beat
        send_frame(fill(16'h1234), fill(16'h1234));
        wait_result(lat, o, s);
        chk("equal_latency", lat, 3);
        chk("equal_out", o, 0);
        chk("equal_sat", s, 0);

        // Negative difference, squared total far above 32 bits
        send_frame(fill(16'h0000), fill(16'hFFFF));
        wait_result(lat, o, s);
        chk("neg_sat_out", o, 32'hFFFF_FFFF);
        chk("neg_sat_flag", s, 1);

        // Backpressure: diff=3 -> 9*64*4/2 = 1152
        loss_ready = 1'b0;
        send_frame(fill(16'd10), fill(16'd7));
        wait_result(lat, o, s);
        chk("bp_out", o, 1152);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid_hold", loss_valid, 1);
            chk("bp_out_hold", loss_out, 1152);
            chk("bp_sat_hold", loss_sat, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 loss_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_released", loss_valid, 0);
        chk("bp_ready_back", in_ready, 1);
        @(posedge clk);
        #1;

        // Reset after two beats discards them entirely
        send_beat(fill(16'd100), fill(16'd0));
        send_beat(fill(16'd100), fill(16'd0));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send_frame(fill(16'd5), fill(16'd3));
        wait_result(lat, o, s);
        chk("rst_mid_out", o, 512);
        chk("rst_mid_sat", s, 0);

        // Single-beat frames: diff=2 -> 4*64/2 = 128
        content_pixels = fill(16'd3);
        generated_pixels = fill(16'd1);
        in_valid1 = 1'b1;
        hs = 0;
        n = 0;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = in_ready1;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid1 = 1'b0;
        chk("b1_accept", hs, 1);
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (loss_valid1) break;
        end
        chk("b1_latency", lat, 3);
        chk("b1_out", loss_out1, 128);
        chk("b1_sat", loss_sat1, 0);
        @(posedge clk);
        #1;

        // Back-to-back random frames with bubbles between beats
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < NB; b++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                for (int i = 0; i < LN; i++) begin
                    rc[i*PW +: PW] = (f == 1) ? PW'($urandom_range(0, 300))
                                              : PW'($urandom);
                    rg[i*PW +: PW] = (f == 1) ? PW'($urandom_range(0, 300))
                                              : PW'($urandom);
                end
                send_beat(rc, rg);
            end
            frames_sent++;
        end

        n = 0;
        while (results_seen < frames_sent && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("frame_count", results_seen, frames_sent);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout t=%0t", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/content_loss_stream.md
CONTENT_LOSS_STREAM -- requirements
Module: content_loss_stream

Interface
REQ-001 SHALL have parameter PIX_W, default 16: unsigned pixel width.
REQ-002 SHALL have parameter LANES, default 64: pixels per beat, power of two, at least 2.
REQ-003 SHALL have parameter BEATS, default 4: beats per frame, at least 1.
REQ-004 SHALL have parameter OUT_W, default 32: loss output width.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1: the input beat is valid.
REQ-008 SHALL have port in_ready, output, 1: the block can accept a beat.
REQ-009 SHALL have port content_pixels, input, LANES x PIX_W: content lanes; lane i is at bits [i*PIX_W +: PIX_W].
REQ-010 SHALL have port generated_pixels, input, LANES x PIX_W: generated lanes, same packing.
REQ-011 SHALL have port loss_valid, output, 1: the frame result is valid.
REQ-012 SHALL have port loss_ready, input, 1: the consumer accepts the result.
REQ-013 SHALL have port loss_out, output, OUT_W: frame loss.
REQ-014 SHALL have port loss_sat, output, 1: loss_out was saturated.

Function
REQ-015 SHALL accept a beat when in_valid and in_ready are both high in the same cycle.
REQ-016 SHALL form each lane difference as a signed PIX_W+1 bit value: content minus generated.
REQ-017 SHALL compute each squared difference exactly at 2*(PIX_W+1) bits.
REQ-018 SHALL use pipeline stage 1 to register the LANES squares of the accepted beat.
REQ-019 SHALL use pipeline stage 2 to register the lane sum, exact at 2*(PIX_W+1)+clog2(LANES) bits.
REQ-020 SHALL use stage 3 to add the lane sum into the frame accumulator, sized with clog2(BEATS)+1 extra bits so it never wraps.
REQ-021 SHALL compute the frame loss as the accumulator shifted right by 1 (floor of sum/2).
REQ-022 SHALL, when the frame loss exceeds 2^OUT_W-1, output all ones on loss_out and set loss_sat=1; otherwise loss_sat=0.
REQ-023 SHALL count accepted beats modulo BEATS; the beat where the count reaches BEATS-1 is the last beat of the frame.
REQ-024 SHALL have FSM states IDLE, ACCUM, DRAIN, DONE.
REQ-025 SHALL transition IDLE->ACCUM on the first accepted beat; when BEATS=1 it SHALL go IDLE->DRAIN directly.
REQ-026 SHALL transition ACCUM->DRAIN when the last beat is accepted.
REQ-027 SHALL transition DRAIN->DONE when the last beat's lane sum has been accumulated.
REQ-028 SHALL assert loss_valid exactly 3 cycles after the last-beat handshake.
REQ-029 SHALL transition DONE->IDLE on loss_valid and loss_ready both high; the accumulator SHALL clear in that same cycle.
REQ-030 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in DRAIN and DONE.
REQ-031 SHALL keep loss_out and loss_sat stable while loss_valid=1 and loss_ready=0.
REQ-032 SHALL allow the next frame's first beat to be accepted in the cycle after the result handshake.
REQ-033 SHALL tolerate in_valid gaps (bubbles) within a frame without affecting the result.

Reset
REQ-034 SHALL, while rst=1, set the FSM to IDLE and clear the beat counter, accumulator, and pipeline valid bits.
REQ-035 SHALL hold in_ready=0, loss_valid=0, loss_out=0, loss_sat=0 while rst=1.
REQ-036 SHALL, on reset mid-frame, discard the partial frame completely; the first frame after reset SHALL use only post-reset beats.

Structure
REQ-037 SHALL place the state enum and the accumulator-width and lane-sum-width calculation functions in the shared package content_loss_pkg.
REQ-038 SHALL implement stages 1-2 (difference, square, adder tree, registers) in one sub-module named sq_diff_sum, instantiated once.

Verification
REQ-039 SHALL verify with defaults: all lanes content=generated=0x1234 for 4 beats -> loss_out=0, loss_sat=0, loss_valid 3 cycles after the last beat.
REQ-040 SHALL verify with BEATS=1: content=3, generated=1 on all 64 lanes -> loss_out=128.
REQ-041 SHALL verify sign handling and saturation: content=0, generated=0xFFFF, 4 beats -> loss_out=0xFFFFFFFF, loss_sat=1.
REQ-042 SHALL verify backpressure: loss_ready held low for 5 cycles -> loss_valid, loss_out and loss_sat held stable; in_ready=0 throughout.
REQ-043 SHALL verify reset mid-frame: rst for 1 cycle after 2 beats, then a full frame of diff=2 on all lanes -> loss_out=4*64*4/2=512.
REQ-044 SHALL verify back-to-back frames with random in_valid bubbles -> each loss_out matches the reference model and no beat is lost or duplicated.
